sha1_block_sequencer: RTL and testbench
=======================================

// Module: sha1_block_sequencer
// PURPOSE
//  Front-end controller for the SHA1 compression kernel. Collects a 32-bit word stream into one 512-bit
//  block, launches the kernel and waits for completion. Chains the running hash across consecutive blocks
//  of one message. Presents the final 160-bit digest on a valid/ready output.
//  Sits between the message source (already padded) and the kernel. The sequencer owns the kernel exclusively.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles k_start may wait for k_done before the error abort
//  WORDS_PER_BLK 16  words per block; fixed, exposed only for the bench
// PORTS
//  clk        in   1    single clock, rising edge
//  reset_n    in   1    synchronous, active-low reset
//  s_valid    in   1    input word valid
//  s_ready    out  1    sequencer can accept a word
//  s_data     in   32   message word, big-endian SHA1 word order
//  s_last     in   1    marks word 15 of the final block of a message
//  k_start    out  1    kernel start level
//  k_block    out  512  block to kernel; word0 at [511:480]
//  k_iv       out  160  chaining value to kernel; A at [159:128]
//  k_done     in   1    kernel completion pulse, 1 cycle
//  k_digest   in   160  kernel result = k_iv + compression; valid when k_done=1
//  d_valid    out  1    digest valid
//  d_ready    in   1    digest consumer ready
//  d_digest   out  160  final message digest
//  busy       out  1    high in every state except IDLE
//  err        out  1    sticky protocol/timeout error; cleared only by reset
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk edge) is valid in every state: state->IDLE, wcnt=0, H=SHA1 IV
//    (67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0), and all outputs 0 (s_ready=0, k_start=0,
//    d_valid=0, d_digest=0, err=0, busy=0). A kernel run in progress is abandoned.
//  - States: IDLE, FILL, LAUNCH, WAIT, CHAIN, OUT.
//  - IDLE: s_ready=1. The first accepted word (s_valid&s_ready) goes to FILL with wcnt=1.
//  - FILL: s_ready=1. Each accept writes buf[wcnt] and increments wcnt. Accepting word 15 goes to LAUNCH
//    and latches last=s_last. A word is never accepted outside IDLE/FILL.
//  - s_last with wcnt!=15: set err, discard the block, reset H to IV, go to IDLE.
//  - LAUNCH: drives k_start=1 and clears tcnt to 0. Next state is WAIT.
//  - k_start stays 1 from LAUNCH until the cycle after k_done. The kernel edge-detects it, so the level must
//    last >=2 cycles; WAIT guarantees this.
//  - k_block and k_iv are held stable from LAUNCH until k_done.
//  - WAIT: tcnt increments each cycle.
//  - WAIT, k_done=1: H<=k_digest, go to CHAIN.
//  - WAIT, tcnt==TIMEOUT_CYC without k_done: set err, drop k_start, H=IV, go to IDLE.
//  - CHAIN: if last, d_digest<=H, d_valid<=1, go to OUT. Otherwise go to IDLE and keep H for the next block.
//  - OUT: d_digest is held until d_valid&d_ready. Then d_valid<=0, H<=IV, go to IDLE.
//    If d_ready=1 already on the first OUT cycle, the transfer completes in that cycle.
//  - Latency: last word accepted -> k_start = 1 cycle; k_done -> d_valid = 2 cycles.
//  - k_done outside WAIT is ignored. An extra k_done in WAIT after the first is impossible,
//    because the state leaves WAIT on the first one.
//  - Widths: wcnt 4 bit, wraps 15->0 only via the LAUNCH transition. tcnt is $clog2(TIMEOUT_CYC+1) bits and saturates.
// CONFIGURATION
//  SHA1_SEQ_BLKCNT_EN defined:
//    - adds output blk_cnt[15:0]: blocks compressed for the current message.
//    - blk_cnt increments on k_done in WAIT and clears when the OUT transfer completes or on reset.
//    - blk_cnt saturates at 16'hFFFF.
//  SHA1_SEQ_BLKCNT_EN undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Package sha1_seq_pkg holds: the state enum seq_state_t; localparam SHA1_IV[4:0]; the word_t (logic[31:0])
//    and digest_t (logic[159:0]) typedefs. The kernel and the bench share this package.
//  - One sub-module: sha1_seq_wordbuf, a 16x32 register file with write-enable/index and a flat 512-bit read.
//    The FSM, counters and chaining register stay in the top module.
//  - No arithmetic beyond the counters; the IV addition lives in the kernel.
// TESTING
//  1. Single block, input "abc" (61626380, 00...0, 00000018) with s_last on word 15
//     -> d_digest=a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, k_start once.
//  2. Two blocks, input "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"
//     -> block 2 k_iv equals block 1 k_digest; d_digest=84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1.
//  3. Backpressure: d_ready=0 for 20 cycles in OUT -> d_valid and d_digest stable, s_ready=0.
//     Then d_ready=1 -> one transfer, IDLE with H=IV.
//  4. s_last asserted on word 7 -> err=1, no k_start. The next "abc" message still yields the case-1 digest.
//  5. Kernel model never pulses k_done -> after TIMEOUT_CYC=255 WAIT cycles, err=1, k_start=0, state IDLE.
//  6. reset_n=0 for 1 cycle mid-WAIT -> all outputs 0 next cycle. A late k_done is ignored,
//     and case 1 passes afterwards.
//  (SHA1_SEQ_BLKCNT_EN) In case 2, blk_cnt reads 2 during OUT and 0 after the transfer.

Source files
------------

// File: rtl/sha1_seq_pkg.sv
// Shared types and constants for the SHA1 block sequencer, its kernel and its bench.
package sha1_seq_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [159:0] digest_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LAUNCH,
    ST_WAIT,
    ST_CHAIN,
    ST_OUT
  } seq_state_t;

  // Index 4 holds A, index 0 holds E.
  localparam word_t SHA1_IV [4:0] = '{
    32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0
  };

  localparam digest_t SHA1_IV_FLAT = {SHA1_IV[4], SHA1_IV[3], SHA1_IV[2], SHA1_IV[1], SHA1_IV[0]};

endpackage

// File: rtl/sha1_seq_wordbuf.sv
// 16x32 block buffer: one indexed write port, whole block read flat with word 0 in the top bits.
module sha1_seq_wordbuf
  import sha1_seq_pkg::*;
(
  input  logic         clk,
  input  logic         i_we,
  input  logic [3:0]   i_idx,
  input  word_t        i_data,
  output logic [511:0] o_flat
);

  word_t r_mem [16];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_data;
  end

  for (genvar g = 0; g < 16; g++) begin : g_flat
    assign o_flat[511-32*g -: 32] = r_mem[g];
  end

endmodule

// File: rtl/sha1_block_sequencer.sv
// Collects 16-word blocks, runs the SHA1 kernel, chains H across blocks and emits the digest.
// Defining SHA1_SEQ_BLKCNT_EN adds the blk_cnt output (blocks compressed for the current message).
//
// state  | meaning
// IDLE   | H ready, waiting for the first word of a block
// FILL   | accepting words 1..15 of the block
// LAUNCH | raise k_start, clear timeout counter
// WAIT   | kernel running; k_start held, timeout counting
// CHAIN  | H updated; emit digest if last block, else next block
// OUT    | digest presented until d_ready
module sha1_block_sequencer
  import sha1_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC   = 255,
  parameter int WORDS_PER_BLK = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  word_t        s_data,
  input  logic         s_last,
  output logic         k_start,
  output logic [511:0] k_block,
  output digest_t      k_iv,
  input  logic         k_done,
  input  digest_t      k_digest,
  output logic         d_valid,
  input  logic         d_ready,
  output digest_t      d_digest,
  output logic         busy,
  output logic         err
`ifdef SHA1_SEQ_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TO_VAL   = TW'(TIMEOUT_CYC);
  localparam logic [3:0]      LAST_IDX = 4'(WORDS_PER_BLK - 1);

  seq_state_t    r_state, w_state_nxt;
  logic [3:0]    r_wcnt;
  logic [TW-1:0] r_tcnt;
  logic          r_last, r_s_ready, r_k_start, r_d_valid, r_err;
  digest_t       r_h, r_d_digest;
  logic          w_accept, w_abort, w_kdone, w_xfer;

  sha1_seq_wordbuf u_wordbuf (
    .clk    (clk),
    .i_we   (w_accept),
    .i_idx  (r_wcnt),
    .i_data (s_data),
    .o_flat (k_block)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    w_accept    = s_valid & r_s_ready;
    w_kdone     = (r_state == ST_WAIT) & k_done;
    w_xfer      = (r_state == ST_OUT) & r_d_valid & d_ready;
    case (r_state)
      ST_IDLE, ST_FILL: begin
        if (w_accept) begin
          if (s_last && (r_wcnt != LAST_IDX)) begin
            w_abort     = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (r_wcnt == LAST_IDX) begin
            w_state_nxt = ST_LAUNCH;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end
      end
      ST_LAUNCH: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (k_done) begin
          w_state_nxt = ST_CHAIN;
        end else if (r_tcnt == TO_VAL) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHAIN: w_state_nxt = r_last ? ST_OUT : ST_IDLE;
      ST_OUT:   if (w_xfer) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_wcnt     <= '0;
      r_tcnt     <= '0;
      r_last     <= 1'b0;
      r_s_ready  <= 1'b0;
      r_k_start  <= 1'b0;
      r_d_valid  <= 1'b0;
      r_err      <= 1'b0;
      r_h        <= SHA1_IV_FLAT;
      r_d_digest <= '0;
    end else begin
      r_state   <= w_state_nxt;
      // Registered so that every output reads 0 in the cycle right after reset.
      r_s_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FILL);
      r_k_start <= (w_state_nxt == ST_LAUNCH) || (w_state_nxt == ST_WAIT);

      if (w_abort) begin
        r_err  <= 1'b1;
        r_wcnt <= '0;
        r_h    <= SHA1_IV_FLAT;
      end else if (w_accept) begin
        r_wcnt <= r_wcnt + 4'd1;
        if (r_wcnt == LAST_IDX) r_last <= s_last;
      end

      if (r_state == ST_LAUNCH) begin
        r_tcnt <= '0;
      end else if ((r_state == ST_WAIT) && (r_tcnt != TO_VAL)) begin
        r_tcnt <= r_tcnt + TW'(1);
      end

      if (w_kdone) r_h <= k_digest;

      if ((r_state == ST_CHAIN) && r_last) begin
        r_d_digest <= r_h;
        r_d_valid  <= 1'b1;
      end

      if (w_xfer) begin
        r_d_valid <= 1'b0;
        r_h       <= SHA1_IV_FLAT;
      end
    end
  end

`ifdef SHA1_SEQ_BLKCNT_EN
  logic [15:0] r_blk_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || w_xfer) begin
      r_blk_cnt <= '0;
    end else if (w_kdone && (r_blk_cnt != 16'hFFFF)) begin
      r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`endif

  assign s_ready  = r_s_ready;
  assign k_start  = r_k_start;
  assign k_iv     = r_h;
  assign d_valid  = r_d_valid;
  assign d_digest = r_d_digest;
  assign busy     = (r_state != ST_IDLE);
  assign err      = r_err;

endmodule

// File: tb/tb_sha1_block_sequencer.sv
// Bench for sha1_block_sequencer: behavioural SHA1 kernel, message-level digest model, random traffic.
`timescale 1ns/1ps
module tb_sha1_block_sequencer;
  import sha1_seq_pkg::*;

  localparam int      TIMEOUT_CYC = 255;
  localparam digest_t IV  = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam digest_t ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam digest_t TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  word_t        s_data = '0;
  logic         s_last = 1'b0;
  logic         k_start;
  logic [511:0] k_block;
  digest_t      k_iv;
  logic         k_done;
  digest_t      k_digest;
  logic         d_valid;
  logic         d_ready = 1'b0;
  digest_t      d_digest;
  logic         busy;
  logic         err;
`ifdef SHA1_SEQ_BLKCNT_EN
  logic [15:0]  blk_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int           n_start = 0;
  int           stable_err = 0;
  bit           kern_mute = 1'b0;
  int           kern_lat_fix = -1;
  digest_t      iv_log[$];
  logic [511:0] blk_log[$];
  int           lat_log[$];
  int           since_done = -1;
  logic         dv_prev = 1'b0;
  word_t        msg_q[$];
  bit           exp_err = 1'b0;

  sha1_block_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .WORDS_PER_BLK(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .k_start(k_start), .k_block(k_block), .k_iv(k_iv), .k_done(k_done), .k_digest(k_digest),
    .d_valid(d_valid), .d_ready(d_ready), .d_digest(d_digest),
    .busy(busy), .err(err)
`ifdef SHA1_SEQ_BLKCNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic digest_t sha1_compress(input digest_t iv, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = iv[159:128]; b = iv[127:96]; c = iv[95:64]; d = iv[63:32]; e = iv[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {iv[159:128] + a, iv[127:96] + b, iv[95:64] + c, iv[63:32] + d, iv[31:0] + e};
  endfunction

  // Kernel stand-in: edge-detects k_start, answers with iv + compression after a delay.
  initial begin : kernel_model
    logic         kprev;
    logic         pend;
    int           cnt;
    digest_t      cap_iv;
    logic [511:0] cap_blk;
    kprev = 1'b0; pend = 1'b0; cnt = 0; cap_iv = '0; cap_blk = '0;
    k_done = 1'b0; k_digest = '0;
    forever begin
      @(posedge clk); #1;
      k_done   = 1'b0;
      k_digest = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (k_start && !kprev) begin
        n_start++;
        cap_iv  = k_iv;
        cap_blk = k_block;
        iv_log.push_back(k_iv);
        blk_log.push_back(k_block);
        pend = !kern_mute;
        cnt  = (kern_lat_fix >= 0) ? kern_lat_fix : int'($urandom_range(0, 6));
      end else if (pend) begin
        if (k_start && ((k_iv !== cap_iv) || (k_block !== cap_blk))) stable_err++;
        if (cnt == 0) begin
          k_done   = 1'b1;
          k_digest = sha1_compress(cap_iv, cap_blk);
          pend     = 1'b0;
        end else begin
          cnt--;
        end
      end
      kprev = k_start;
    end
  end

  // Cycles from the k_done pulse to the rising edge of d_valid.
  always @(negedge clk) begin
    if (k_done) since_done = 0;
    else if (since_done >= 0) since_done++;
    if (d_valid && !dv_prev) lat_log.push_back(since_done);
    dv_prev = d_valid;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"},  s_ready,  0);
    chk({tag, "_k_start"},  k_start,  0);
    chk({tag, "_d_valid"},  d_valid,  0);
    chk({tag, "_d_digest"}, d_digest, 0);
    chk({tag, "_err"},      err,      0);
    chk({tag, "_busy"},     busy,     0);
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_last = 1'b0; d_ready = 1'b0;
    reset_n = 1'b0;
    cyc(); cyc();
    check_all_zero("rst");
    reset_n = 1'b1;
    cyc();
    chk("rst_then_ready", s_ready, 1);
  endtask

  task automatic send_word(input word_t d, input logic last);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && n < 400) begin cyc(); n++; end
    chk("s_ready_wait", n < 400, 1);
    cyc();
    s_valid = 1'b0; s_last = 1'b0; s_data = $urandom();
  endtask

  task automatic send_all(input int gap);
    for (int i = 0; i < msg_q.size(); i++) begin
      repeat ($urandom_range(0, gap)) cyc();
      send_word(msg_q[i], i == msg_q.size() - 1);
      if (i % 16 == 15) chk("launch_latency", k_start, 1);
    end
  endtask

  function automatic void load_abc();
    msg_q.delete();
    msg_q.push_back(32'h61626380);
    for (int i = 1; i < 15; i++) msg_q.push_back(32'h0);
    msg_q.push_back(32'h00000018);
  endfunction

  function automatic void load_two();
    word_t txt [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                        32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                        32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
    msg_q.delete();
    for (int i = 0; i < 14; i++) msg_q.push_back(txt[i]);
    msg_q.push_back(32'h80000000);
    for (int i = 0; i < 16; i++) msg_q.push_back(32'h0);
    msg_q.push_back(32'h000001c0);
  endfunction

  function automatic void load_random(input int nblk);
    msg_q.delete();
    for (int i = 0; i < 16 * nblk; i++) msg_q.push_back($urandom());
  endfunction

  task automatic run_msg(input int hold, input bit pre_ready, input int gap,
                         input bit use_lit, input digest_t lit);
    int           nblk, iv0, st0, n;
    digest_t      h;
    digest_t      ivs[$];
    logic [511:0] blks[$];
    logic [511:0] blk;
    nblk = msg_q.size() / 16;
    iv0  = iv_log.size();
    st0  = n_start;
    h    = IV;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 16; j++) blk[511-32*j -: 32] = msg_q[16*b+j];
      ivs.push_back(h);
      blks.push_back(blk);
      h = sha1_compress(h, blk);
    end
    lat_log.delete();
    d_ready = pre_ready;
    send_all(gap);
    n = 0;
    while (!d_valid && n < 600) begin cyc(); n++; end
    chk("d_valid_wait", n < 600, 1);
    chk("digest_model", d_digest, h);
    if (use_lit) chk("digest_known", d_digest, lit);
    chk("launch_count", n_start - st0, nblk);
    for (int b = 0; b < nblk; b++) begin
      if (iv0 + b < iv_log.size()) begin
        chk("k_iv", iv_log[iv0+b], ivs[b]);
        chk("k_block", blk_log[iv0+b], blks[b]);
      end
    end
`ifdef SHA1_SEQ_BLKCNT_EN
    chk("blk_cnt_out", blk_cnt, nblk);
`endif
    if (!pre_ready) begin
      for (int c = 0; c < hold; c++) begin
        chk("hold_d_valid", d_valid, 1);
        chk("hold_d_digest", d_digest, h);
        chk("hold_s_ready", s_ready, 0);
        cyc();
      end
      d_ready = 1'b1;
    end
    cyc();
    d_ready = 1'b0;
    chk("xfer_d_valid", d_valid, 0);
    chk("xfer_busy", busy, 0);
    chk("err_state", err, exp_err);
`ifdef SHA1_SEQ_BLKCNT_EN
    chk("blk_cnt_clear", blk_cnt, 0);
`endif
    chk("kdone_dvalid_seen", lat_log.size(), 1);
    while (lat_log.size() > 0) chk("kdone_to_dvalid", lat_log.pop_front(), 2);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: run did not reach summary, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin : main
    int n, n0, bad;
    do_reset();

    load_abc();  run_msg(0, 1'b0, 3, 1'b1, ABC);
    load_two();  run_msg(20, 1'b0, 2, 1'b1, TWO);

    for (int r = 0; r < 6; r++) begin
      load_random($urandom_range(1, 3));
      run_msg($urandom_range(0, 5), 1'($urandom_range(0, 1)), 3, 1'b0, '0);
    end

    n0 = n_start;
    for (int i = 0; i < 8; i++) send_word($urandom(), i == 7);
    chk("slast_err", err, 1);
    chk("slast_busy", busy, 0);
    repeat (3) cyc();
    chk("slast_no_launch", n_start - n0, 0);
    exp_err = 1'b1;
    load_abc();  run_msg(0, 1'b1, 1, 1'b1, ABC);

    do_reset();
    exp_err = 1'b0;
    kern_lat_fix = 30;
    load_abc();  send_all(0);
    repeat (5) cyc();
    chk("mid_wait_busy", busy, 1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    check_all_zero("midrst");
    bad = 0;
    repeat (45) begin
      cyc();
      if (d_valid || busy || err) bad++;
    end
    chk("late_kdone_ignored", bad, 0);
    kern_lat_fix = -1;
    load_abc();  run_msg(3, 1'b0, 2, 1'b1, ABC);

    kern_mute = 1'b1;
    load_abc();  send_all(0);
    n = 0;
    while (!err && n < 400) begin cyc(); n++; end
    chk("timeout_cycles", n, TIMEOUT_CYC + 2);
    chk("timeout_err", err, 1);
    chk("timeout_k_start", k_start, 0);
    chk("timeout_busy", busy, 0);
    chk("timeout_s_ready", s_ready, 1);
    chk("kernel_inputs_stable", stable_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
